cpu_clk_ctrl: RTL and testbench

Clock-enable controller for the board-level MIPS CPU. It replaces the divided-clock scheme with single-`CLK`-wide `CPU_CE` pulses, so the CPU runs on the board clock. It supports free-run at two switch-selected rates, single-step from a push button, and halt on CPU request. It sits between the board I/O (switches, button) and the CPU core's clock-enable input.

---
 rtl/cpu_clk_pkg.sv | 16 +
 rtl/btn_debounce.sv | 56 +++++
 rtl/cpu_clk_ctrl.sv | 142 ++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared types and default constants for the CPU clock-enable controller.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    S_STEP = 2'd0,
    S_REL  = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } clk_state_t;

  localparam int unsigned DEF_FAST_PERIOD = 32'd67108864;
  localparam int unsigned DEF_SLOW_PERIOD = 32'd536870912;
  localparam int unsigned DEF_DEB_CYCLES  = 32'd1000000;
  localparam int unsigned DEF_CNT_W       = 32'd32;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for a raw board button.
// Outputs the debounced level and a one-cycle pulse on its rising edge.
module btn_debounce
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic LEVEL,
  output logic RISE
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the input agrees with the current level restarts the count.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync_q[1];
      rise_d  = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], BTN};
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LEVEL = level_q;
  assign RISE  = rise_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Clock-enable controller for the MIPS CPU: free-run, single-step and halt.
// Optional breakpoint ports and logic are enabled by defining CPU_CLK_CTRL_BP_EN.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned FAST_PERIOD = DEF_FAST_PERIOD,
  parameter int unsigned SLOW_PERIOD = DEF_SLOW_PERIOD,
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SW15,
  input  logic             RUN,
  input  logic             STEP_BTN,
  input  logic             HALT_REQ,
  input  logic             CLR_HALT,
`ifdef CPU_CLK_CTRL_BP_EN
  input  logic [31:0]      PC,
  input  logic [31:0]      BP_ADDR,
  input  logic             BP_VALID,
`endif
  output logic             CPU_CE,
  output logic             HALTED,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] TICK_CNT
);

  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(FAST_PERIOD - 1);
  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(SLOW_PERIOD - 1);

  logic [1:0]       sw_sync_q, run_sync_q;
  logic             sw_s, run_s;
  logic             btn_level, btn_rise;
  logic             halt_hit;
  logic [CNT_W-1:0] period_m1;

  clk_state_t       state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             ce_q, ce_d;
  logic             halted_q, halted_d;

  assign sw_s      = sw_sync_q[1];
  assign run_s     = run_sync_q[1];
  assign period_m1 = sw_s ? SLOW_M1 : FAST_M1;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_btn (
    .CLK  (CLK),
    .RST_N(RST_N),
    .BTN  (STEP_BTN),
    .LEVEL(btn_level),
    .RISE (btn_rise)
  );

`ifdef CPU_CLK_CTRL_BP_EN
  logic bp_armed_q, bp_armed_d;

  assign halt_hit = HALT_REQ | (BP_VALID && (PC == BP_ADDR) && bp_armed_q &&
                                ((state_q == S_RUN) || (state_q == S_STEP)));

  // Disarm on leaving HALT so the CPU can step past the breakpoint; re-arm after one pulse.
  always_comb begin
    bp_armed_d = bp_armed_q;
    if (ce_q) bp_armed_d = 1'b1;
    if ((state_q == S_HALT) && (state_d != S_HALT)) bp_armed_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) bp_armed_q <= 1'b1;
    else        bp_armed_q <= bp_armed_d;
  end
`else
  assign halt_hit = HALT_REQ;
`endif

  always_comb begin
    state_d = state_q;
    presc_d = '0;
    ce_d    = 1'b0;
    if ((state_q != S_HALT) && halt_hit) begin
      state_d = S_HALT;
    end else begin
      unique case (state_q)
        S_STEP: begin
          if (run_s) begin
            state_d = S_RUN;
          end else if (btn_rise) begin
            ce_d    = 1'b1;
            state_d = S_REL;
          end
        end
        S_REL: begin
          if (run_s)           state_d = S_RUN;
          else if (!btn_level) state_d = S_STEP;
        end
        S_RUN: begin
          // >= so a slow-to-fast switch mid-count fires at once instead of wrapping.
          if (!run_s)                    state_d = S_STEP;
          else if (presc_q >= period_m1) ce_d    = 1'b1;
          else                           presc_d = presc_q + CNT_W'(1);
        end
        S_HALT: begin
          if (CLR_HALT && !HALT_REQ) begin
            state_d = run_s ? S_RUN : (btn_level ? S_REL : S_STEP);
          end
        end
        default: state_d = S_STEP;
      endcase
    end
    tick_d   = tick_q + CNT_W'(ce_d);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_sync_q  <= '0;
      run_sync_q <= '0;
      state_q    <= S_STEP;
      presc_q    <= '0;
      tick_q     <= '0;
      ce_q       <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      sw_sync_q  <= {sw_sync_q[0], SW15};
      run_sync_q <= {run_sync_q[0], RUN};
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      ce_q       <= ce_d;
      halted_q   <= halted_d;
    end
  end

  assign CPU_CE   = ce_q;
  assign HALTED   = halted_q;
  assign STATE    = state_q;
  assign TICK_CNT = tick_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed self-checking bench for cpu_clk_ctrl with short periods and debounce.
module tb_cpu_clk_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N, SW15, RUN, STEP_BTN, HALT_REQ, CLR_HALT;
  logic        CPU_CE, HALTED;
  logic [1:0]  STATE;
  logic [31:0] TICK_CNT;
`ifdef CPU_CLK_CTRL_BP_EN
  logic [31:0] PC, BP_ADDR;
  logic        BP_VALID;
`endif

  int errors = 0;
  int checks = 0;
  int n;

  always #5 CLK = ~CLK;

  cpu_clk_ctrl #(
    .FAST_PERIOD(8),
    .SLOW_PERIOD(32),
    .DEB_CYCLES (4),
    .CNT_W      (32)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .SW15    (SW15),
    .RUN     (RUN),
    .STEP_BTN(STEP_BTN),
    .HALT_REQ(HALT_REQ),
    .CLR_HALT(CLR_HALT),
`ifdef CPU_CLK_CTRL_BP_EN
    .PC      (PC),
    .BP_ADDR (BP_ADDR),
    .BP_VALID(BP_VALID),
`endif
    .CPU_CE  (CPU_CE),
    .HALTED  (HALTED),
    .STATE   (STATE),
    .TICK_CNT(TICK_CNT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; SW15 = 1'b0; RUN = 1'b1; STEP_BTN = 1'b0; HALT_REQ = 1'b0; CLR_HALT = 1'b0;
`ifdef CPU_CLK_CTRL_BP_EN
    PC = '0; BP_ADDR = '0; BP_VALID = 1'b0;
`endif
    tick(); tick(); tick();
    chk("rst_state", 32'(STATE), 0);
    chk("rst_ce", 32'(CPU_CE), 0);
    chk("rst_halted", 32'(HALTED), 0);
    chk("rst_tick", TICK_CNT, 0);

    // Free-run, fast period
    RST_N = 1'b1;
    for (int i = 0; i < 10 && STATE !== 2'd2; i++) tick();
    chk("enter_run", 32'(STATE), 2);
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("fast_ce", 32'(CPU_CE), 32'(i % 8 == 0));
    end
    chk("tick_after_40", TICK_CNT, 5);

    // Slow period, then slow-to-fast switch with prescaler at 20
    SW15 = 1'b1;
    tick();
    n = 1;
    while (CPU_CE !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("slow_gap", 32'(n), 32);
    for (int i = 0; i < 18; i++) tick();
    SW15 = 1'b0;
    tick(); chk("sw_fast_wait1", 32'(CPU_CE), 0);
    tick(); chk("sw_fast_wait2", 32'(CPU_CE), 0);
    tick(); chk("sw_fast_fire", 32'(CPU_CE), 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("sw_fast_period", 32'(CPU_CE), 32'(i == 8));
    end

    // Halt on the cycle the pulse would fire
    for (int i = 0; i < 7; i++) tick();
    HALT_REQ = 1'b1;
    tick();
    chk("halt_ce_suppressed", 32'(CPU_CE), 0);
    chk("halt_halted", 32'(HALTED), 1);
    chk("halt_state", 32'(STATE), 3);
    CLR_HALT = 1'b1;
    tick();
    chk("clr_while_req", 32'(STATE), 3);
    HALT_REQ = 1'b0;
    tick();
    CLR_HALT = 1'b0;
    chk("clr_to_run", 32'(STATE), 2);
    chk("clr_halted", 32'(HALTED), 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("resume_ce", 32'(CPU_CE), 32'(i == 8));
    end
    chk("tick_after_halt", TICK_CNT, 9);

    // Step mode: clean press
    RUN = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("step_state", 32'(STATE), 0);
    STEP_BTN = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("step_latency", 32'(CPU_CE), 32'(i == 7));
    end
    chk("step_rel", 32'(STATE), 1);
    n = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (CPU_CE === 1'b1) n++;
    end
    chk("step_held_no_extra", 32'(n), 0);
    STEP_BTN = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("step_release", 32'(STATE), 0);
    chk("tick_after_step", TICK_CNT, 10);

    // Bouncy press
    n = 0;
    for (int i = 0; i < 6; i++) begin
      STEP_BTN = (i % 2 == 0);
      tick();
      if (CPU_CE === 1'b1) n++;
    end
    STEP_BTN = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (CPU_CE === 1'b1) n++;
    end
    STEP_BTN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (CPU_CE === 1'b1) n++;
    end
    chk("bounce_one_pulse", 32'(n), 1);
    chk("tick_after_bounce", TICK_CNT, 11);

    // Reset mid-pulse in S_REL with button held
    STEP_BTN = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_ce", 32'(CPU_CE), 1);
    chk("pre_rst_state", 32'(STATE), 1);
    RST_N = 1'b0;
    #1;
    chk("async_rst_ce", 32'(CPU_CE), 0);
    chk("async_rst_state", 32'(STATE), 0);
    chk("async_rst_halted", 32'(HALTED), 0);
    chk("async_rst_tick", TICK_CNT, 0);
    STEP_BTN = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    tick(); tick(); tick();
    n = 0;
    STEP_BTN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (CPU_CE === 1'b1) n++;
    end
    STEP_BTN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (CPU_CE === 1'b1) n++;
    end
    chk("post_rst_one_pulse", 32'(n), 1);
    chk("post_rst_tick", TICK_CNT, 1);

`ifdef CPU_CLK_CTRL_BP_EN
    // Breakpoint at the fifth instruction
    PC = 32'h0040_0000; BP_ADDR = 32'h0040_0010; BP_VALID = 1'b1; RUN = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && HALTED !== 1'b1; i++) begin
      tick();
      if (CPU_CE === 1'b1) begin
        n++;
        PC = PC + 32'd4;
      end
    end
    chk("bp_halted", 32'(HALTED), 1);
    chk("bp_pulses", 32'(n), 4);
    CLR_HALT = 1'b1;
    tick();
    CLR_HALT = 1'b0;
    chk("bp_clr_run", 32'(STATE), 2);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (CPU_CE === 1'b1) begin
        n++;
        PC = PC + 32'd4;
      end
    end
    chk("bp_resumed_state", 32'(STATE), 2);
    chk("bp_resumed_pulses", 32'(n), 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
